daq_frame_unpacker: RTL

//  Receive side of the 64-bit DAQ link. Consumes framed DAQ words (HEADER1, HEADER2, data words, TRAILER)
//  and re-serialises the payload into a 32-bit channel stream with an end-of-frame marker.

---
 rtl/daq_frame_unpacker.sv | 105 ++++++++++
 1 files changed

// File: rtl/daq_frame_unpacker.sv
// daq_frame_unpacker: unpacks framed 64-bit DAQ words into a 32-bit channel stream,
// recovering the fill number and checking header/trailer signatures.
module daq_frame_unpacker #(
    parameter bit          DROP_ZERO_PAD = 1'b1,
    parameter logic [31:0] HDR_SIG       = 32'h00000008,
    parameter logic [63:0] HDR2_WORD     = 64'h000000000000FFFF,
    parameter logic [23:0] TRL_SIG       = 24'h000008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] daq_data,
    input  logic        daq_valid,
    input  logic        daq_header,
    input  logic        daq_trailer,
    output logic        daq_ready,
    output logic [31:0] chan_data,
    output logic        chan_valid,
    output logic        chan_last,
    input  logic        chan_ready,
    output logic [23:0] fill_num,
    output logic        fill_valid,
    input  logic        fill_ready,
    output logic        frame_err,
    output logic        err_header,
    output logic        err_trailer,
    output logic        err_seq
);
    typedef enum logic [2:0] {WAIT_HDR, HDR2, WAIT_DATA, HOLD, EMIT_HI, EMIT_LO, DONE} state_t;
    state_t state, state_n;
    logic [63:0] hold_q, out_q;
    logic lastp, accept, hdr_ok, trl_ok;
    logic load_fill, load_hold, load_out, e_hdr, e_trl, e_seq;
    assign accept = daq_valid & daq_ready;
    assign hdr_ok = daq_data[31:0] == HDR_SIG;
    assign trl_ok = daq_data[63:26] == 38'h0 && daq_data[25:24] == fill_num[1:0] && daq_data[23:0] == TRL_SIG;
    assign daq_ready = state inside {WAIT_HDR, HDR2, WAIT_DATA, HOLD};
    assign chan_valid = state == EMIT_HI || state == EMIT_LO;
    assign chan_data = state == EMIT_HI ? out_q[63:32] : out_q[31:0];
    // the low half of the final word is suppressed when it is only zero padding
    assign chan_last = state == EMIT_HI ? lastp & DROP_ZERO_PAD & (out_q[31:0] == 32'h0)
                                        : state == EMIT_LO && lastp;
    assign fill_valid = state == DONE;
    always_comb begin
        state_n = state;
        load_fill = 1'b0;
        load_hold = 1'b0;
        load_out = 1'b0;
        e_hdr = 1'b0;
        e_trl = 1'b0;
        e_seq = 1'b0;
        case (state)
            WAIT_HDR, HDR2, WAIT_DATA, HOLD: if (accept) begin
                if (daq_header) begin
                    state_n = hdr_ok ? HDR2 : WAIT_HDR;
                    load_fill = hdr_ok;
                    e_hdr = !hdr_ok || state == HDR2;
                    e_seq = state == WAIT_DATA || state == HOLD;
                end else if (state == WAIT_HDR) begin
                    e_seq = 1'b1;
                end else if (state == HDR2) begin
                    e_hdr = daq_trailer || daq_data != HDR2_WORD;
                    state_n = e_hdr ? WAIT_HDR : WAIT_DATA;
                end else if (state == WAIT_DATA) begin
                    e_seq = daq_trailer;
                    load_hold = !daq_trailer;
                    state_n = daq_trailer ? WAIT_HDR : HOLD;
                end else begin
                    load_out = 1'b1;
                    load_hold = !daq_trailer;
                    e_trl = daq_trailer & !trl_ok;
                    state_n = EMIT_HI;
                end
            end
            EMIT_HI: state_n = chan_ready ? (chan_last ? DONE : EMIT_LO) : EMIT_HI;
            EMIT_LO: state_n = chan_ready ? (lastp ? DONE : HOLD) : EMIT_LO;
            DONE:    state_n = fill_ready ? WAIT_HDR : DONE;
            default: state_n = WAIT_HDR;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_HDR;
            hold_q <= 64'h0;
            out_q <= 64'h0;
            lastp <= 1'b0;
            fill_num <= 24'h0;
            frame_err <= 1'b0;
            err_header <= 1'b0;
            err_trailer <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            state <= state_n;
            err_header <= e_hdr;
            err_trailer <= e_trl;
            err_seq <= e_seq;
            frame_err <= load_fill ? 1'b0 : frame_err | e_trl;
            if (load_fill) fill_num <= daq_data[55:32];
            if (load_hold) hold_q <= daq_data;
            if (load_out) begin
                out_q <= hold_q;
                lastp <= daq_trailer;
            end
        end
    end
endmodule
